shift_sequencer: RTL
====================

Name: shift_sequencer

Overview:
- Multi-cycle shift/rotate unit for the 16-bit RISC datapath.
- Owns a WIDTH-bit universal shift register (hold / shift-right / shift-left / parallel-load).
- Sequences it one bit per clock to execute SLL, SRL, SRA, ROL and ROR by a variable amount.
- Sits between the decode/execute control and the register file write-back; uses a START/BUSY/DONE handshake.

Parameters:
WIDTH, 16, datapath width; must be a power of 2, at least 4.
CNT_W, 4, shift-amount width, log2(WIDTH).

Ports:
CLOCK  input  1  system clock, rising edge.
RESET  input  1  synchronous, active-high reset.
ENABLE  input  1  clock enable; when 0 all state holds.
START  input  1  command strobe, sampled in IDLE only.
OP  input  3  opcode: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; 101-111 illegal.
AMOUNT  input  CNT_W  shift count, 0..WIDTH-1.
DATA_IN  input  WIDTH  operand.
RESULT  output  WIDTH  shift register contents; final value valid while DONE=1.
BUSY  output  1  high in SHIFT state.
DONE  output  1  one-cycle completion pulse.
ILLEGAL  output  1  high with DONE when the captured OP was illegal.

Behaviour:
- Single clock, CLOCK. RESET is synchronous and active-high.
- RESET (any state, including mid-shift):
  - state = IDLE
  - RESULT = 0, BUSY = 0, DONE = 0, ILLEGAL = 0
  - count = 0, op register = SLL
  - RESET overrides ENABLE.
- ENABLE = 0: FSM, counter, op register and shift register hold. DONE holds its current level. START is ignored.
- Register modes (S1,S0):
  - 00 hold
  - 01 shift right: serial-in enters the MSB
  - 10 shift left: serial-in enters the LSB
  - 11 parallel load
- FSM states: IDLE, SHIFT, FIN.
- IDLE, START=1:
  - Parallel-load DATA_IN (mode 11).
  - Capture OP, and AMOUNT into count.
  - Next state is SHIFT if AMOUNT > 0 and OP is legal; otherwise FIN.
- IDLE, START=0: mode 00, remain in IDLE.
- SHIFT, one bit per enabled cycle:
  - SLL: mode 10, serial-in 0.
  - SRL: mode 01, serial-in 0.
  - SRA: mode 01, serial-in = current MSB.
  - ROL: mode 10, serial-in = current MSB.
  - ROR: mode 01, serial-in = current LSB.
  - count decrements each cycle; when count == 1 at the edge, next state is FIN.
- FIN:
  - DONE = 1 and mode 00 for exactly one enabled cycle.
  - ILLEGAL = 1 if the captured OP is 101-111.
  - Next state IDLE.
- Latency: START in cycle c0 produces DONE in cycle c0+AMOUNT+1. AMOUNT = 0 or an illegal OP gives DONE at c0+1 with RESULT = DATA_IN.
- BUSY = 1 only in SHIFT. DONE is never high together with BUSY.
- START while in SHIFT or FIN is ignored, not queued. START in the same cycle DONE is high is also ignored; the next command is accepted from IDLE.
- RESULT holds its final value after DONE until the next accepted START.
- DATA_IN, OP and AMOUNT are don't-care except in the START cycle.
- Counter arithmetic is unsigned CNT_W bits and never wraps: it only decrements while count ≥ 1.

Decomposition:
- Package shift_pkg holds:
  - opcode constants OP_SLL..OP_ROR
  - mode constants MODE_HOLD=00, MODE_SHR=01, MODE_SHL=10, MODE_LOAD=11
  - state typedef {IDLE, SHIFT, FIN}
- One sub-module, shreg_universal: WIDTH-parameterised universal shift register with ports CLOCK, RESET, ENABLE, S1, S0, SER_IN, IN, OUT.
- shift_sequencer contains the FSM, counter, opcode register and serial-in mux.

Test Plan:
- SLL: DATA_IN=0x00F1, AMOUNT=4, START at c0 -> BUSY in c1..c4, DONE=1 only in c5, RESULT=0x0F10, ILLEGAL=0.
- SRA then SRL:
  - SRA: DATA_IN=0x8010, AMOUNT=3 -> RESULT=0xF002, DONE at c4.
  - SRL with the same operands -> 0x1002.
- Rotates:
  - ROR: 0x0001, AMOUNT=1 -> 0x8000, DONE at c2.
  - ROL: 0x8001, AMOUNT=15 -> 0xC000, DONE at c16.
- AMOUNT=0 (SLL, 0x1234) and illegal OP=111 (0xBEEF, AMOUNT=5):
  - both give DONE at c1 with RESULT = DATA_IN, BUSY never high
  - ILLEGAL=1 only for OP=111.
- START (SLL, 0x0001, AMOUNT=8):
  - START pulsed again at c3 with different data -> ignored; RESULT=0x0100, DONE at c9.
  - RESET at c4 of a repeat run -> next cycle RESULT=0, BUSY=0, DONE=0, state IDLE.
- ENABLE stall: SRL 0xFF00 by 4, ENABLE=0 during c2..c4 -> RESULT and count frozen, DONE delayed to c8, RESULT=0x0FF0.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared constants and types for the multi-cycle shift/rotate unit.
package shift_pkg;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FIN
    } state_t;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_ROR;
    endfunction

endpackage

// File: rtl/shreg_universal.sv
// Universal shift register: hold, shift right, shift left, parallel load.
module shreg_universal
    import shift_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic             S1,
    input  logic             S0,
    input  logic             SER_IN,
    input  logic [WIDTH-1:0] IN,
    output logic [WIDTH-1:0] OUT
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_q <= '0;
        end else if (ENABLE) begin
            unique case ({S1, S0})
                MODE_HOLD: r_q <= r_q;
                MODE_SHR:  r_q <= {SER_IN, r_q[WIDTH-1:1]};
                MODE_SHL:  r_q <= {r_q[WIDTH-2:0], SER_IN};
                MODE_LOAD: r_q <= IN;
            endcase
        end
    end

    assign OUT = r_q;

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA/ROL/ROR unit, one bit per enabled clock,
// with a START/BUSY/DONE handshake toward decode and write-back.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic             START,
    input  logic [2:0]       OP,
    input  logic [CNT_W-1:0] AMOUNT,
    input  logic [WIDTH-1:0] DATA_IN,
    output logic [WIDTH-1:0] RESULT,
    output logic             BUSY,
    output logic             DONE,
    output logic             ILLEGAL
);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_count;
    logic [2:0]       r_op;
    logic [1:0]       w_mode;
    logic [1:0]       w_shift_mode;
    logic             w_ser_in;
    logic             w_accept;
    logic [WIDTH-1:0] w_q;

    assign w_accept = (r_state == IDLE) && START;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state <= IDLE;
            r_count <= '0;
            r_op    <= OP_SLL;
        end else if (ENABLE) begin
            r_state <= w_next;
            if (w_accept) begin
                r_op    <= OP;
                r_count <= AMOUNT;
            end else if (r_state == SHIFT && r_count != '0) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Direction and fill bit both follow the captured opcode.
    always_comb begin
        w_shift_mode = MODE_HOLD;
        w_ser_in     = 1'b0;
        unique case (r_op)
            OP_SLL: w_shift_mode = MODE_SHL;
            OP_SRL: w_shift_mode = MODE_SHR;
            OP_SRA: begin
                w_shift_mode = MODE_SHR;
                w_ser_in     = w_q[WIDTH-1];
            end
            OP_ROL: begin
                w_shift_mode = MODE_SHL;
                w_ser_in     = w_q[WIDTH-1];
            end
            OP_ROR: begin
                w_shift_mode = MODE_SHR;
                w_ser_in     = w_q[0];
            end
            default: begin
                w_shift_mode = MODE_HOLD;
                w_ser_in     = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_next = r_state;
        w_mode = MODE_HOLD;
        unique case (r_state)
            IDLE: begin
                if (START) begin
                    w_mode = MODE_LOAD;
                    if (AMOUNT != '0 && op_legal(OP))
                        w_next = SHIFT;
                    else
                        w_next = FIN;
                end
            end
            SHIFT: begin
                w_mode = w_shift_mode;
                if (r_count <= CNT_W'(1))
                    w_next = FIN;
            end
            FIN: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    shreg_universal #(
        .WIDTH(WIDTH)
    ) u_shreg (
        .CLOCK  (CLOCK),
        .RESET  (RESET),
        .ENABLE (ENABLE),
        .S1     (w_mode[1]),
        .S0     (w_mode[0]),
        .SER_IN (w_ser_in),
        .IN     (DATA_IN),
        .OUT    (w_q)
    );

    assign RESULT  = w_q;
    assign BUSY    = (r_state == SHIFT);
    assign DONE    = (r_state == FIN);
    assign ILLEGAL = DONE && !op_legal(r_op);

endmodule
